usb_rx_router: RTL and testbench
================================

# usb_rx_router

Receive-side word router that sits directly downstream of the FT601 controller's read path. It captures each 32-bit word the controller presents with `rd_data_valid`, buffers it in a small skid FIFO, decodes the destination from the header bits, and writes it into the addressed peripheral's input FIFO or into the configuration port. It drives the controller's `lycan_in_full` backpressure, sized so words already in flight when full asserts are never lost.

## Interface
- `NUM_PERIPH`, 8: number of peripheral input FIFOs, 1..8.
- `SKID_DEPTH`, 4: skid FIFO entries, power of two, ≥4.
- `clk` in 1: single clock, shared with the FT601 controller.
- `rst` in 1: synchronous reset, active-high.
- `word_in` in 32: word from the FT601 read path.
- `word_valid` in 1: `word_in` valid this cycle; connects to the controller's `rd_data_valid`.
- `in_full` out 1: backpressure; connects to the controller's `lycan_in_full`.
- `periph_full` in NUM_PERIPH: per-peripheral input FIFO full.
- `periph_wr_en` out NUM_PERIPH: one-hot-or-zero write strobe, registered.
- `periph_data` out 32: word to peripheral FIFOs, registered.
- `cfg_data` out 32: configuration word.
- `cfg_valid` out 1: `cfg_data` valid.
- `cfg_ready` in 1: configuration sink accepts.
- `overflow` out 1: sticky; a word arrived while the skid FIFO was full.
- `drop_count` out 16: words dropped for an invalid address (`ROUTER_STATS_EN` only).
- `word_count` out 32: words delivered (`ROUTER_STATS_EN` only).

## Operation
- Header: `word[31:29]` is the address and `word[28]` is the config flag. The word is forwarded unmodified.
- Capture: when `word_valid` is high and occupancy < SKID_DEPTH, write `word_in` at the tail. At occupancy == SKID_DEPTH, discard the word and set `overflow`. `overflow` clears only on `rst`.
- `in_full` = occupancy ≥ SKID_DEPTH−2 (combinational from the registered count). Two entries of headroom cover the controller's read-enable turnaround.
- Dispatch FSM:
  - `IDLE`: FIFO empty; outputs idle.
  - `DISPATCH`: examine the head word.
    - Config flag set: load `cfg_data`, raise `cfg_valid`, pop the head, and go to `CFG_WAIT`.
    - Address ≥ NUM_PERIPH: pop and drop the word; increment `drop_count`, which saturates at 0xFFFF.
    - `periph_full[addr]` low: pop; on the next edge register `periph_wr_en[addr]`=1 and `periph_data`=word.
    - Destination full: hold the head word (head-of-line block, no reordering); `periph_wr_en`=0.
  - `CFG_WAIT`: hold `cfg_valid`/`cfg_data` until `cfg_ready` is sampled high, then go to `DISPATCH`, or to `IDLE` if the FIFO is empty.
- At most one pop per cycle. A simultaneous push and pop leaves occupancy unchanged. Pointers wrap modulo SKID_DEPTH.
- A push into an empty FIFO is not visible to dispatch in the same cycle.
- `rst` mid-operation empties the FIFO, forces `IDLE`, and discards any pending config word.

## Timing
- Reset values:
  - `periph_wr_en`=0, `periph_data`=0
  - `cfg_valid`=0, `cfg_data`=0
  - `in_full`=0, `overflow`=0
  - `drop_count`=0, `word_count`=0
- Latency: a word sampled at edge k into an empty FIFO gives `periph_wr_en` high in the cycle after edge k+2. That is two cycles of latency.
- Throughput: one word per cycle sustained while destinations are not full.
- `cfg_valid` rises one cycle after the pop. The transfer completes on the edge where `cfg_valid` and `cfg_ready` are both high. `cfg_data` is stable while `cfg_valid` is high and not yet accepted.
- `word_count` increments on the edge that registers `periph_wr_en` or completes a `cfg` handshake.

## Configuration
- `ROUTER_STATS_EN` defined: `drop_count` and `word_count` are implemented as specified.
- Undefined: both ports are tied to 0 and no counter flops are synthesised. Routing, drop and overflow behaviour is identical in both builds.

## Test plan
- Post-reset `word_valid` burst of 4 words 0x2000_0001..0x2000_0004 to address 1, `periph_full`=0:
  - `periph_wr_en`=0b0000_0010 for 4 consecutive cycles starting 2 cycles after the first word.
  - Data appears in order; `word_count`=4.
- Word 0x6000_00AA with `periph_full[3]`=1 for 5 cycles, followed by 3 more words:
  - No write while address 3 is full; `in_full` asserts at occupancy 2.
  - After release, all 4 words are delivered in order.
- Word 0x1000_0055 (config) with `cfg_ready` low for 3 cycles:
  - `cfg_valid` is held high with `cfg_data`=0x1000_0055 until `cfg_ready` goes high.
  - Exactly one transfer occurs; the FIFO drains afterwards.
- With NUM_PERIPH=4, word 0xE000_0000:
  - No `periph_wr_en` strobe; `drop_count`=1.
  - The following valid word is delivered normally.
- Hold `periph_full`=all-ones and drive 5 words:
  - Occupancy stops at 4; `overflow`=1 and stays set.
  - After `periph_full` clears, exactly the first 4 words are delivered.
- Assert `rst` with 3 words buffered:
  - The next cycle shows all outputs at reset values and the FIFO empty.
  - No stale word is delivered after reset releases.

Source files
------------

// File: rtl/usb_rx_router.sv
// Receive-side word router: skid-buffers FT601 read words and dispatches them to peripheral FIFOs or the config port.
// Optional build macro: ROUTER_STATS_EN enables the drop_count / word_count statistics counters.
module usb_rx_router #(
  parameter int NUM_PERIPH = 8,
  parameter int SKID_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           word_in,
  input  logic                  word_valid,
  output logic                  in_full,
  input  logic [NUM_PERIPH-1:0] periph_full,
  output logic [NUM_PERIPH-1:0] periph_wr_en,
  output logic [31:0]           periph_data,
  output logic [31:0]           cfg_data,
  output logic                  cfg_valid,
  input  logic                  cfg_ready,
  output logic                  overflow,
  output logic [15:0]           drop_count,
  output logic [31:0]           word_count
);

  localparam int PW = $clog2(SKID_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(SKID_DEPTH);
  localparam logic [CW-1:0] FULL_THR = CW'(SKID_DEPTH - 2);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_DISPATCH = 2'd1;
  localparam logic [1:0] S_CFG_WAIT = 2'd2;

  logic [31:0]           r_mem [SKID_DEPTH];
  logic [PW-1:0]         r_wr_ptr;
  logic [PW-1:0]         r_rd_ptr;
  logic [CW-1:0]         r_count;
  logic [1:0]            r_state;
  logic [NUM_PERIPH-1:0] r_periph_wr_en;
  logic [31:0]           r_periph_data;
  logic [31:0]           r_cfg_data;
  logic                  r_cfg_valid;
  logic                  r_overflow;

  logic [31:0]           w_head;
  logic [2:0]            w_addr;
  logic                  w_is_cfg;
  logic                  w_addr_bad;
  logic                  w_dest_full;
  logic [NUM_PERIPH-1:0] w_onehot;
  logic                  w_push;
  logic                  w_active;
  logic                  w_cfg_take;
  logic                  w_drop;
  logic                  w_deliver;
  logic                  w_pop;
  logic                  w_cfg_done;
  logic [CW-1:0]         w_count_next;
  logic [1:0]            w_state_next;

  assign w_head     = r_mem[r_rd_ptr];
  assign w_addr     = w_head[31:29];
  assign w_is_cfg   = w_head[28];
  assign w_addr_bad = ({1'b0, w_addr} >= 4'(NUM_PERIPH));

  // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    w_dest_full = 1'b0;
    w_onehot    = '0;
    for (int i = 0; i < NUM_PERIPH; i++) begin
      if (w_addr == 3'(i)) begin
        w_dest_full = periph_full[i];
        w_onehot[i] = 1'b1;
      end
    end
  end

  // A full skid FIFO discards the incoming word; head-of-line blocking keeps ordering intact.
  assign w_push       = word_valid && (r_count != DEPTH_C);
  assign w_active     = (r_state == S_DISPATCH) && (r_count != '0);
  assign w_cfg_take   = w_active && w_is_cfg;
  assign w_drop       = w_active && !w_is_cfg && w_addr_bad;
  assign w_deliver    = w_active && !w_is_cfg && !w_addr_bad && !w_dest_full;
  assign w_pop        = w_cfg_take || w_drop || w_deliver;
  assign w_cfg_done   = (r_state == S_CFG_WAIT) && r_cfg_valid && cfg_ready;
  assign w_count_next = r_count + CW'(w_push) - CW'(w_pop);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:     if (r_count != '0) w_state_next = S_DISPATCH;
      S_DISPATCH: begin
        if (w_cfg_take)                w_state_next = S_CFG_WAIT;
        else if (w_count_next == '0)   w_state_next = S_IDLE;
      end
      S_CFG_WAIT: if (w_cfg_done) w_state_next = (r_count != '0) ? S_DISPATCH : S_IDLE;
      default:    w_state_next = S_IDLE;
    endcase
  end

  // NOTE: the skid storage has no reset; the pointers and count alone decide which entries are live.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= word_in;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_count        <= '0;
      r_state        <= S_IDLE;
      r_periph_wr_en <= '0;
      r_periph_data  <= '0;
      r_cfg_data     <= '0;
      r_cfg_valid    <= 1'b0;
      r_overflow     <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count        <= w_count_next;
      r_state        <= w_state_next;
      r_periph_wr_en <= w_deliver ? w_onehot : '0;
      if (w_deliver) r_periph_data <= w_head;
      if (w_cfg_take) begin
        r_cfg_data  <= w_head;
        r_cfg_valid <= 1'b1;
      end else if (w_cfg_done) begin
        r_cfg_valid <= 1'b0;
      end
      if (word_valid && (r_count == DEPTH_C)) r_overflow <= 1'b1;
    end
  end

  assign in_full      = (r_count >= FULL_THR);
  assign periph_wr_en = r_periph_wr_en;
  assign periph_data  = r_periph_data;
  assign cfg_data     = r_cfg_data;
  assign cfg_valid    = r_cfg_valid;
  assign overflow     = r_overflow;

`ifdef ROUTER_STATS_EN
  logic [15:0] r_drop_count;
  logic [31:0] r_word_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_drop_count <= '0;
      r_word_count <= '0;
    end else begin
      if (w_drop && (r_drop_count != 16'hFFFF)) r_drop_count <= r_drop_count + 1'b1;
      if (w_deliver || w_cfg_done)              r_word_count <= r_word_count + 1'b1;
    end
  end

  assign drop_count = r_drop_count;
  assign word_count = r_word_count;
`else
  assign drop_count = '0;
  assign word_count = '0;
`endif

endmodule

// File: tb/tb_usb_rx_router.sv
// Directed self-checking bench for usb_rx_router (NUM_PERIPH=4, SKID_DEPTH=4).
// Counter expectations follow ROUTER_STATS_EN so the same bench serves both builds.
module tb_usb_rx_router;

  localparam int NP = 4;
`ifdef ROUTER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic          clk;
  logic          rst;
  logic [31:0]   word_in;
  logic          word_valid;
  logic          in_full;
  logic [NP-1:0] periph_full;
  logic [NP-1:0] periph_wr_en;
  logic [31:0]   periph_data;
  logic [31:0]   cfg_data;
  logic          cfg_valid;
  logic          cfg_ready;
  logic          overflow;
  logic [15:0]   drop_count;
  logic [31:0]   word_count;

  int n_checks = 0;
  int n_fail   = 0;
  int cfg_xfers = 0;

  usb_rx_router #(.NUM_PERIPH(NP), .SKID_DEPTH(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .word_in      (word_in),
    .word_valid   (word_valid),
    .in_full      (in_full),
    .periph_full  (periph_full),
    .periph_wr_en (periph_wr_en),
    .periph_data  (periph_data),
    .cfg_data     (cfg_data),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .overflow     (overflow),
    .drop_count   (drop_count),
    .word_count   (word_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst && cfg_valid && cfg_ready) cfg_xfers++;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_wr_en"},  32'(periph_wr_en), 32'h0);
    check({tag, "_pdata"},  periph_data,       32'h0);
    check({tag, "_cvalid"}, 32'(cfg_valid),    32'h0);
    check({tag, "_cdata"},  cfg_data,          32'h0);
    check({tag, "_infull"}, 32'(in_full),      32'h0);
    check({tag, "_ovf"},    32'(overflow),     32'h0);
    check({tag, "_drop"},   32'(drop_count),   32'h0);
    check({tag, "_wcnt"},   word_count,        32'h0);
  endtask

  initial begin
    rst = 1'b1; word_in = '0; word_valid = 1'b0; periph_full = '0; cfg_ready = 1'b0;
    tick(); tick();
    check_reset_values("rst");
    rst = 1'b0;
    tick();

    // Burst of 4 words to address 1: strobes after edges k+2..k+5.
    for (int i = 0; i < 8; i++) begin
      word_valid = (i < 4);
      word_in    = 32'h2000_0001 + 32'(i);
      tick();
      check("t1_wr_en", 32'(periph_wr_en), (i >= 2 && i <= 5) ? 32'h2 : 32'h0);
      if (i >= 2 && i <= 5) check("t1_data", periph_data, 32'h2000_0001 + 32'(i - 2));
    end
    check("t1_wcnt", word_count, STATS ? 32'd4 : 32'd0);
    check("t1_infull", 32'(in_full), 32'h0);

    // Address 3 blocked for 5 edges, then 4 words drain in order.
    for (int i = 0; i < 10; i++) begin
      word_valid  = (i < 4);
      word_in     = 32'h6000_00AA + 32'(i);
      periph_full = (i < 5) ? 4'b1000 : 4'b0000;
      tick();
      check("t2_wr_en", 32'(periph_wr_en), (i >= 5 && i <= 8) ? 32'h8 : 32'h0);
      if (i >= 5 && i <= 8) check("t2_data", periph_data, 32'h6000_00AA + 32'(i - 5));
      check("t2_infull", 32'(in_full), (i >= 1 && i <= 6) ? 32'h1 : 32'h0);
    end
    check("t2_wcnt", word_count, STATS ? 32'd8 : 32'd0);

    // Config word held until cfg_ready is sampled high at edge k+6.
    for (int i = 0; i < 9; i++) begin
      word_valid = (i == 0);
      word_in    = 32'h1000_0055;
      cfg_ready  = (i >= 6);
      tick();
      check("t3_cvalid", 32'(cfg_valid), (i >= 2 && i <= 5) ? 32'h1 : 32'h0);
      if (i >= 2 && i <= 5) check("t3_cdata", cfg_data, 32'h1000_0055);
      check("t3_wr_en", 32'(periph_wr_en), 32'h0);
    end
    cfg_ready = 1'b0;
    check("t3_xfers", 32'(cfg_xfers), 32'd1);
    check("t3_wcnt", word_count, STATS ? 32'd9 : 32'd0);
    check("t3_infull", 32'(in_full), 32'h0);

    // Address 7 >= NUM_PERIPH is dropped; following word to address 2 is delivered.
    for (int i = 0; i < 7; i++) begin
      word_valid = (i < 2);
      word_in    = (i == 0) ? 32'hE000_0000 : 32'h4000_0077;
      tick();
      check("t4_wr_en", 32'(periph_wr_en), (i == 3) ? 32'h4 : 32'h0);
      if (i == 3) check("t4_data", periph_data, 32'h4000_0077);
    end
    check("t4_drop", 32'(drop_count), STATS ? 32'd1 : 32'd0);
    check("t4_wcnt", word_count, STATS ? 32'd10 : 32'd0);

    // All destinations full, 5 words: fifth is lost, overflow sticks.
    for (int i = 0; i < 12; i++) begin
      word_valid  = (i < 5);
      word_in     = 32'h0000_0001 + 32'(i);
      periph_full = (i < 5) ? 4'hF : 4'h0;
      tick();
      check("t5_wr_en", 32'(periph_wr_en), (i >= 5 && i <= 8) ? 32'h1 : 32'h0);
      if (i >= 5 && i <= 8) check("t5_data", periph_data, 32'h0000_0001 + 32'(i - 5));
      check("t5_ovf", 32'(overflow), (i >= 4) ? 32'h1 : 32'h0);
    end
    check("t5_wcnt", word_count, STATS ? 32'd14 : 32'd0);
    check("t5_drop", 32'(drop_count), STATS ? 32'd1 : 32'd0);

    // Reset with 3 words buffered behind a full destination.
    periph_full = 4'hF;
    for (int i = 0; i < 3; i++) begin
      word_valid = 1'b1;
      word_in    = 32'h2000_0010 + 32'(i);
      tick();
    end
    word_valid = 1'b0;
    check("t6_pre_infull", 32'(in_full), 32'h1);
    rst = 1'b1;
    tick();
    check_reset_values("t6");
    rst = 1'b0;
    periph_full = 4'h0;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("t6_stale", 32'(periph_wr_en), 32'h0);
    end
    check("t6_cvalid", 32'(cfg_valid), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
